nlms_host_bridge: RTL and testbench

NLMS_HOST_BRIDGE -- requirements
Module: nlms_host_bridge

---
 rtl/nlms_host_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_nlms_host_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/nlms_host_bridge.sv
// nlms_host_bridge
//   Host BRAM-port bridge for an NLMS filter core. A single word-addressed
//   BRAM-style port is decoded into the core's x/d sample buffers, the
//   h coefficient buffer (assembled into NUM_MULS-wide blocks), the output
//   buffer read path and a small register file (CONFIG, X_COUNT, H_BLOCKS,
//   CONTROL, STATUS).
//
//   Word map (in order): X | D | H | OUT | CONFIG | X_COUNT | H_BLOCKS |
//   CONTROL | STATUS. Everything beyond STATUS is unmapped.
//
// Ports
//   bram_clk_a / bram_rst_a        : clock, synchronous active-high reset
//   bram_en/we/addr/wrdata/rddata  : host port, read data one cycle after read
//   x_buff_*, d_buff_*             : per-channel sample writes (same cycle)
//   h_buff_*                       : assembled coefficient block writes
//   out_buff_*                     : output buffer read (1-cycle latency)
//   config_word, x_samples_count,
//   h_coef_blocks_count            : register values to the core
//   start, sw_rst                  : one-cycle command pulses
//   busy / finished                : core run handshake
module nlms_host_bridge #(
   parameter int LOG2_NUM_CH          = 1,
   parameter int LOG2_X_D_BUFF_HEIGHT = 10,
   parameter int LOG2_H_BUFF_HEIGHT   = 8,
   parameter int LOG2_NUM_MULS        = 2,
   parameter int SAMPLE_WIDTH         = 16,
   parameter int BRAM_ADDR_WIDTH      = 16,
   parameter int BRAM_DATA_WIDTH      = 32,
   localparam int NUM_CH   = 2 ** LOG2_NUM_CH,
   localparam int NUM_MULS = 2 ** LOG2_NUM_MULS
) (
   input  logic                               bram_clk_a,
   input  logic                               bram_rst_a,
   input  logic                               bram_en,
   input  logic [BRAM_DATA_WIDTH/8-1:0]       bram_we,
   input  logic [BRAM_ADDR_WIDTH-1:0]         bram_addr,
   input  logic [BRAM_DATA_WIDTH-1:0]         bram_wrdata,
   output logic [BRAM_DATA_WIDTH-1:0]         bram_rddata,
   output logic [NUM_CH-1:0]                  x_buff_we,
   output logic [LOG2_X_D_BUFF_HEIGHT-1:0]    x_buff_waddr,
   output logic [SAMPLE_WIDTH-1:0]            x_buff_wdata,
   output logic [NUM_CH-1:0]                  d_buff_we,
   output logic [LOG2_X_D_BUFF_HEIGHT-1:0]    d_buff_waddr,
   output logic [SAMPLE_WIDTH-1:0]            d_buff_wdata,
   output logic                               h_buff_we,
   output logic [LOG2_H_BUFF_HEIGHT-1:0]      h_buff_waddr,
   output logic [NUM_MULS*SAMPLE_WIDTH-1:0]   h_buff_wdata,
   output logic                               out_buff_re,
   output logic [LOG2_NUM_CH-1:0]             out_buff_ch,
   output logic [LOG2_X_D_BUFF_HEIGHT-1:0]    out_buff_raddr,
   input  logic [SAMPLE_WIDTH-1:0]            out_buff_rdata,
   output logic [SAMPLE_WIDTH-1:0]            config_word,
   output logic [SAMPLE_WIDTH-1:0]            x_samples_count,
   output logic [SAMPLE_WIDTH-1:0]            h_coef_blocks_count,
   output logic                               start,
   output logic                               sw_rst,
   output logic                               busy,
   input  logic                               finished
);

   localparam int XOFF_W = LOG2_NUM_CH + LOG2_X_D_BUFF_HEIGHT;
   localparam int HOFF_W = LOG2_H_BUFF_HEIGHT + LOG2_NUM_MULS;

   localparam int unsigned X_SIZE    = 2 ** XOFF_W;
   localparam int unsigned H_SIZE    = 2 ** HOFF_W;
   localparam int unsigned D_BASE    = X_SIZE;
   localparam int unsigned H_BASE    = 2 * X_SIZE;
   localparam int unsigned OUT_BASE  = H_BASE + H_SIZE;
   localparam int unsigned CFG_ADDR  = OUT_BASE + X_SIZE;
   localparam int unsigned XCNT_ADDR = CFG_ADDR + 1;
   localparam int unsigned HBLK_ADDR = CFG_ADDR + 2;
   localparam int unsigned CTRL_ADDR = CFG_ADDR + 3;
   localparam int unsigned STAT_ADDR = CFG_ADDR + 4;

   // ---------------------------------------------------------------- decode
   logic [31:0]                  a;
   logic                         wr, rd;
   logic                         in_x, in_d, in_h, in_o;
   logic [SAMPLE_WIDTH-1:0]      wd;
   logic [XOFF_W-1:0]            x_off, d_off, o_off;
   logic [HOFF_W-1:0]            h_off;
   logic                         unused_wrdata_hi;

   assign a    = 32'(bram_addr);
   assign wr   = bram_en && (|bram_we);
   assign rd   = bram_en && (bram_we == '0);
   assign wd   = bram_wrdata[SAMPLE_WIDTH-1:0];
   assign unused_wrdata_hi = ^bram_wrdata[BRAM_DATA_WIDTH-1:SAMPLE_WIDTH];

   assign in_x = (a < D_BASE);
   assign in_d = (a >= D_BASE)   && (a < H_BASE);
   assign in_h = (a >= H_BASE)   && (a < OUT_BASE);
   assign in_o = (a >= OUT_BASE) && (a < CFG_ADDR);

   // Region offsets; only the low bits are meaningful inside a region.
   assign x_off = XOFF_W'(a);
   assign d_off = XOFF_W'(a - D_BASE);
   assign o_off = XOFF_W'(a - OUT_BASE);
   assign h_off = HOFF_W'(a - H_BASE);

   // ----------------------------------------------------- x/d/out (comb)
   assign x_buff_waddr   = x_off[LOG2_X_D_BUFF_HEIGHT-1:0];
   assign x_buff_wdata   = wd;
   assign d_buff_waddr   = d_off[LOG2_X_D_BUFF_HEIGHT-1:0];
   assign d_buff_wdata   = wd;
   assign out_buff_ch    = o_off[XOFF_W-1:LOG2_X_D_BUFF_HEIGHT];
   assign out_buff_raddr = o_off[LOG2_X_D_BUFF_HEIGHT-1:0];

   always_comb begin
      x_buff_we   = '0;
      d_buff_we   = '0;
      out_buff_re = 1'b0;
      if (wr && !busy && in_x)
         x_buff_we[x_off[XOFF_W-1:LOG2_X_D_BUFF_HEIGHT]] = 1'b1;
      if (wr && !busy && in_d)
         d_buff_we[d_off[XOFF_W-1:LOG2_X_D_BUFF_HEIGHT]] = 1'b1;
      if (rd && in_o)
         out_buff_re = 1'b1;
   end

   // ------------------------------------------------------- h assembler
   logic [NUM_MULS-1:0][SAMPLE_WIDTH-1:0] h_data, h_data_nxt;
   logic [NUM_MULS-1:0]                   h_mask, h_mask_nxt, lane_bit;
   logic [LOG2_H_BUFF_HEIGHT-1:0]         h_blk, h_block;
   logic [LOG2_NUM_MULS-1:0]              h_lane;
   logic                                  h_conflict;

   assign h_lane     = h_off[LOG2_NUM_MULS-1:0];
   assign h_block    = h_off[HOFF_W-1:LOG2_NUM_MULS];
   assign lane_bit   = NUM_MULS'(1) << h_lane;
   // A write to another block while lanes are pending drops the partial block.
   assign h_conflict = (|h_mask) && (h_block != h_blk);
   assign h_mask_nxt = (h_conflict ? '0 : h_mask) | lane_bit;

   always_comb begin
      h_data_nxt         = h_data;
      h_data_nxt[h_lane] = wd;
   end

   // ---------------------------------------------------------- registers
   logic [SAMPLE_WIDTH-1:0] ctrl_reg, rd_val, rd_reg;
   logic                    done, h_err, wr_busy_err, out_rd_q;

   always_comb begin
      rd_val = '0;
      if (a == CFG_ADDR)  rd_val = config_word;
      if (a == XCNT_ADDR) rd_val = x_samples_count;
      if (a == HBLK_ADDR) rd_val = h_coef_blocks_count;
      if (a == CTRL_ADDR) rd_val = ctrl_reg;
      if (a == STAT_ADDR) rd_val = SAMPLE_WIDTH'({wr_busy_err, h_err, done, busy});
   end

   // OUT data arrives from the buffer one cycle after out_buff_re, which is
   // the same cycle a registered value would appear, so it is muxed in here.
   assign bram_rddata = out_rd_q ? BRAM_DATA_WIDTH'(out_buff_rdata)
                                 : BRAM_DATA_WIDTH'(rd_reg);

   always_ff @(posedge bram_clk_a) begin
      if (bram_rst_a) begin
         config_word         <= '0;
         x_samples_count     <= '0;
         h_coef_blocks_count <= '0;
         ctrl_reg            <= '0;
         rd_reg              <= '0;
         out_rd_q            <= 1'b0;
         busy                <= 1'b0;
         done                <= 1'b0;
         h_err               <= 1'b0;
         wr_busy_err         <= 1'b0;
         start               <= 1'b0;
         sw_rst              <= 1'b0;
         h_buff_we           <= 1'b0;
         h_buff_waddr        <= '0;
         h_buff_wdata        <= '0;
         h_data              <= '0;
         h_mask              <= '0;
         h_blk               <= '0;
      end else begin
         start     <= 1'b0;
         sw_rst    <= 1'b0;
         h_buff_we <= 1'b0;
         out_rd_q  <= rd && in_o;
         if (rd) rd_reg <= rd_val;

         if (wr) begin
            if (a == CFG_ADDR)  config_word         <= wd;
            if (a == XCNT_ADDR) x_samples_count     <= wd;
            if (a == HBLK_ADDR) h_coef_blocks_count <= wd;
            if (a == CTRL_ADDR) ctrl_reg            <= wd;
            // W1C first; any set event below overrides the clear.
            if (a == STAT_ADDR) begin
               if (wd[1]) done        <= 1'b0;
               if (wd[2]) h_err       <= 1'b0;
               if (wd[3]) wr_busy_err <= 1'b0;
            end
            if ((in_x || in_d || in_h) && busy) wr_busy_err <= 1'b1;
            if (in_h && !busy) begin
               h_data <= h_data_nxt;
               h_blk  <= h_block;
               if (h_conflict) h_err <= 1'b1;
               if (&h_mask_nxt) begin
                  h_buff_we    <= 1'b1;
                  h_buff_waddr <= h_block;
                  h_buff_wdata <= h_data_nxt;
                  h_mask       <= '0;
               end else begin
                  h_mask <= h_mask_nxt;
               end
            end
         end

         if (finished && busy) begin
            busy <= 1'b0;
            done <= 1'b1;
         end

         // Software reset outranks start and every status/assembler update.
         if (wr && (a == CTRL_ADDR)) begin
            if (wd[1]) begin
               sw_rst      <= 1'b1;
               busy        <= 1'b0;
               done        <= 1'b0;
               h_err       <= 1'b0;
               wr_busy_err <= 1'b0;
               h_mask      <= '0;
            end else if (wd[0] && !busy) begin
               start <= 1'b1;
               busy  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_nlms_host_bridge.sv
// Scoreboard bench for nlms_host_bridge (default parameters). The stimulus
// process pushes hand-computed expectations into per-output queues; the
// monitor pops and compares whenever the DUT presents an output.
module tb_nlms_host_bridge;

   localparam int XB = 0, DB = 2048, HB = 4096, OB = 5120;
   localparam int CFG = 7168, XCNT = 7169, HBLK = 7170, CTRL = 7171, STAT = 7172;

   logic        clk = 1'b0, rst = 1'b1;
   logic        en = 1'b0;
   logic [3:0]  we = 4'h0;
   logic [15:0] addr = '0;
   logic [31:0] wdata = '0, rddata;
   logic [1:0]  x_we, d_we;
   logic [9:0]  x_waddr, d_waddr, o_raddr;
   logic [15:0] x_wdata, d_wdata, o_rdata = 16'hDEAD;
   logic        h_we, o_re, o_ch, start, sw_rst, busy, finished = 1'b0;
   logic [7:0]  h_waddr;
   logic [63:0] h_wdata;
   logic [15:0] cfg_w, xcnt_w, hblk_w;

   int passed = 0, total = 0;
   logic [127:0] qx[$], qd[$], qh[$], qo[$], qrd[$], qst[$], qsw[$];
   logic rd_pend = 1'b0;

   nlms_host_bridge dut (
      .bram_clk_a(clk), .bram_rst_a(rst), .bram_en(en), .bram_we(we),
      .bram_addr(addr), .bram_wrdata(wdata), .bram_rddata(rddata),
      .x_buff_we(x_we), .x_buff_waddr(x_waddr), .x_buff_wdata(x_wdata),
      .d_buff_we(d_we), .d_buff_waddr(d_waddr), .d_buff_wdata(d_wdata),
      .h_buff_we(h_we), .h_buff_waddr(h_waddr), .h_buff_wdata(h_wdata),
      .out_buff_re(o_re), .out_buff_ch(o_ch), .out_buff_raddr(o_raddr),
      .out_buff_rdata(o_rdata), .config_word(cfg_w), .x_samples_count(xcnt_w),
      .h_coef_blocks_count(hblk_w), .start(start), .sw_rst(sw_rst),
      .busy(busy), .finished(finished)
   );

   always #5 clk = ~clk;

   // Output buffer model: 1-cycle read latency, garbage when not read.
   always @(posedge clk)
      if (o_re) o_rdata <= 16'hBEE8 ^ 16'(o_raddr) ^ (o_ch ? 16'h0100 : 16'h0000);
      else      o_rdata <= 16'hDEAD;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic unexp(input string nm);
      total++;
      $display("FAIL %s: unexpected output event", nm);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rd_pend) begin
         if (qrd.size() == 0) unexp("rddata");
         else chk("rddata", 128'(rddata), qrd.pop_front());
      end
      rd_pend = en && (we == 4'h0) && !rst;
      if (x_we != '0) begin
         if (qx.size() == 0) unexp("x_write");
         else chk("x_write", 128'({x_we, x_waddr, x_wdata}), qx.pop_front());
      end
      if (d_we != '0) begin
         if (qd.size() == 0) unexp("d_write");
         else chk("d_write", 128'({d_we, d_waddr, d_wdata}), qd.pop_front());
      end
      if (h_we) begin
         if (qh.size() == 0) unexp("h_write");
         else chk("h_write", 128'({h_waddr, h_wdata}), qh.pop_front());
      end
      if (o_re) begin
         if (qo.size() == 0) unexp("out_re");
         else chk("out_re", 128'({o_ch, o_raddr}), qo.pop_front());
      end
      if (start) begin
         if (qst.size() == 0) unexp("start");
         else chk("start_busy", 128'({start, busy}), qst.pop_front());
      end
      if (sw_rst) begin
         if (qsw.size() == 0) unexp("sw_rst");
         else chk("sw_rst_busy", 128'({sw_rst, busy}), qsw.pop_front());
      end
   end

   task automatic wr(input int a, input logic [31:0] d);
      @(posedge clk); #1;
      en = 1'b1; we = 4'hF; addr = 16'(a); wdata = d;
      @(posedge clk); #1;
      en = 1'b0; we = 4'h0;
   endtask

   task automatic rd(input int a, input logic [31:0] exp);
      @(posedge clk); #1;
      qrd.push_back(128'(exp));
      en = 1'b1; we = 4'h0; addr = 16'(a);
      @(posedge clk); #1;
      en = 1'b0;
   endtask

   task automatic fin_pulse();
      @(posedge clk); #1; finished = 1'b1;
      @(posedge clk); #1; finished = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1; rst = 1'b1;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1; rst = 1'b0;
      chk("rst_regs", 128'({cfg_w, xcnt_w, hblk_w}), 128'(0));
      chk("rst_pulses", 128'({start, sw_rst, busy, h_we}), 128'(0));
      rd(STAT, 32'h0);

      // x/d writes, channel decode
      qx.push_back(128'({2'b10, 10'd5, 16'h1234}));
      wr(XB + 1024 + 5, 32'h0000_1234);
      qd.push_back(128'({2'b01, 10'd7, 16'hABCD}));
      wr(DB + 7, 32'hFFFF_ABCD);
      qd.push_back(128'({2'b10, 10'd1023, 16'h5555}));
      wr(DB + 2047, 32'h0000_5555);

      // h block assembled out of order
      qh.push_back(128'({8'd2, 64'h0004_0003_0002_0001}));
      wr(HB + 8, 1); wr(HB + 10, 3); wr(HB + 9, 2); wr(HB + 11, 4);

      // h block switch discards partial block
      wr(HB + 8, 5); wr(HB + 9, 6); wr(HB + 12, 7);
      rd(STAT, 32'h4);
      qh.push_back(128'({8'd3, 64'h000A_0009_0008_0007}));
      wr(HB + 13, 8); wr(HB + 14, 9); wr(HB + 15, 10);
      wr(STAT, 32'h4);
      rd(STAT, 32'h0);

      // register file
      wr(CFG, 32'hFFFF_5A5A);
      wr(XCNT, 32'h0000_0100);
      wr(HBLK, 32'h0000_0040);
      chk("reg_outputs", 128'({cfg_w, xcnt_w, hblk_w}), 128'({16'h5A5A, 16'h0100, 16'h0040}));
      rd(HBLK, 32'h0000_0040);

      // run control
      qst.push_back(128'(2'b11));
      wr(CTRL, 32'h1);
      rd(STAT, 32'h1);
      wr(XB + 3, 32'h0000_7777);          // ignored while busy
      rd(STAT, 32'h9);
      wr(CTRL, 32'h1);                    // start while busy ignored
      rd(STAT, 32'h9);
      fin_pulse();
      rd(STAT, 32'hA);
      wr(STAT, 32'hA);
      rd(STAT, 32'h0);
      rd(CTRL, 32'h1);

      // software reset beats start and clears status
      qst.push_back(128'(2'b11));
      wr(CTRL, 32'h1);
      wr(HB + 0, 32'h0000_0099);           // busy error
      qsw.push_back(128'(2'b10));
      wr(CTRL, 32'h3);
      rd(STAT, 32'h0);
      fin_pulse();                          // idle: ignored
      rd(STAT, 32'h0);

      // output buffer reads and unmapped reads
      qo.push_back(128'({1'b0, 10'd7}));
      rd(OB + 7, 32'h0000_BEEF);
      qo.push_back(128'({1'b1, 10'd1023}));
      rd(OB + 2047, 32'h0000_BC17);
      rd(CFG, 32'h0000_5A5A);
      wr(OB + 3, 32'h1111);                 // silently ignored
      rd(STAT + 1, 32'h0);
      rd(16'hFFFF, 32'h0);

      // reset in the middle of an h block
      wr(HB + 2, 32'hAA); wr(HB + 3, 32'hBB);
      do_reset();
      chk("rst2_regs", 128'({cfg_w, xcnt_w, hblk_w}), 128'(0));
      qh.push_back(128'({8'd0, 64'h0014_0013_0012_0011}));
      wr(HB + 0, 32'h11); wr(HB + 1, 32'h12); wr(HB + 2, 32'h13); wr(HB + 3, 32'h14);
      rd(STAT, 32'h0);

      repeat (4) @(posedge clk);
      chk("drain_x", 128'(qx.size()), 128'(0));
      chk("drain_d", 128'(qd.size()), 128'(0));
      chk("drain_h", 128'(qh.size()), 128'(0));
      chk("drain_out", 128'(qo.size()), 128'(0));
      chk("drain_rd", 128'(qrd.size()), 128'(0));
      chk("drain_start", 128'(qst.size()), 128'(0));
      chk("drain_swrst", 128'(qsw.size()), 128'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
